// File: rtl/zet_sram_pkg.sv
// rtl/zet_sram_pkg.sv - shared state encoding and chip-select width helper for the SRAM bridge
package zet_sram_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_TURN} state_t;

  // Chip-select field is never narrower than one bit, even for a single chip.
  function automatic int chip_bits(input int nchips);
    return (nchips > 1) ? $clog2(nchips) : 1;
  endfunction

endpackage

// File: rtl/sram_bridge_if.sv
// rtl/sram_bridge_if.sv - classic Wishbone slave bus carried into the SRAM bridge
interface sram_bridge_if #(
  parameter int AW = 18,
  parameter int CW = 1
);
  logic [AW+CW-1:0] wb_adr_i;
  logic [15:0]      wb_dat_i;
  logic [15:0]      wb_dat_o;
  logic [1:0]       wb_sel_i;
  logic             wb_we_i;
  logic             wb_stb_i;
  logic             wb_cyc_i;
  logic             wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/sram_bridge.sv
// rtl/sram_bridge.sv - Wishbone to multi-chip 16-bit asynchronous SRAM bridge with wait and turnaround cycles
module sram_bridge
  import zet_sram_pkg::*;
#(
  parameter int AW     = 18,
  parameter int NCHIPS = 2,
  parameter int WAIT   = 1,
  parameter int TURN   = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  sram_bridge_if.slave      wb,
  output logic [AW-1:0]     sram_addr_,
  input  logic [15:0]       sram_dq_i,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic [NCHIPS-1:0] sram_ce_,
  output logic              sram_oe_,
  output logic              sram_we_,
  output logic              sram_ble_,
  output logic              sram_bhe_
);

  localparam int CW = chip_bits(NCHIPS);

  state_t          state, state_nxt;
  logic [3:0]      wait_cnt;
  logic [1:0]      turn_cnt;
  logic            req_we;
  logic [1:0]      req_sel;
  logic [CW-1:0]   req_chip;
  logic            accept;

  logic            cur_we;
  logic [1:0]      cur_sel;
  logic [CW-1:0]   cur_chip;
  logic            cur_valid;
  logic            active;
  logic [NCHIPS-1:0] ce_nxt;
  logic            oe_nxt, we_nxt, ble_nxt, bhe_nxt, dq_oe_nxt;

  assign accept = (state == S_IDLE) && wb.wb_cyc_i && wb.wb_stb_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ACCESS;
      S_ACCESS: if (wait_cnt == 4'd0) state_nxt = S_DONE;
      S_DONE:   state_nxt = (TURN == 0) ? S_IDLE : S_TURN;
      S_TURN:   if (turn_cnt == 2'd0) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // SRAM pins are registered, so their next values follow the next state;
  // on the accepting edge the request fields come straight from the bus.
  always_comb begin
    cur_we    = accept ? wb.wb_we_i : req_we;
    cur_sel   = accept ? wb.wb_sel_i : req_sel;
    cur_chip  = accept ? wb.wb_adr_i[AW+CW-1:AW] : req_chip;
    cur_valid = int'(cur_chip) < NCHIPS;
    active    = (state_nxt == S_ACCESS) || (state_nxt == S_DONE);
    ce_nxt    = '1;
    for (int i = 0; i < NCHIPS; i++) begin
      if (active && cur_valid && int'(cur_chip) == i) ce_nxt[i] = 1'b0;
    end
    oe_nxt    = !((state_nxt == S_ACCESS) && cur_valid && !cur_we);
    we_nxt    = !((state_nxt == S_ACCESS) && cur_valid && cur_we);
    ble_nxt   = active ? ~cur_sel[0] : 1'b1;
    bhe_nxt   = active ? ~cur_sel[1] : 1'b1;
    dq_oe_nxt = active && cur_valid && cur_we;
    wb.wb_ack_o = (state == S_DONE) && wb.wb_cyc_i && wb.wb_stb_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sram_ce_    <= '1;
      sram_oe_    <= 1'b1;
      sram_we_    <= 1'b1;
      sram_ble_   <= 1'b1;
      sram_bhe_   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_addr_  <= '0;
      sram_dq_o   <= '0;
      wb.wb_dat_o <= '0;
      wait_cnt    <= '0;
      turn_cnt    <= '0;
      req_we      <= 1'b0;
      req_sel     <= '0;
      req_chip    <= '0;
    end else begin
      sram_ce_   <= ce_nxt;
      sram_oe_   <= oe_nxt;
      sram_we_   <= we_nxt;
      sram_ble_  <= ble_nxt;
      sram_bhe_  <= bhe_nxt;
      sram_dq_oe <= dq_oe_nxt;
      if (accept) begin
        req_we     <= wb.wb_we_i;
        req_sel    <= wb.wb_sel_i;
        req_chip   <= wb.wb_adr_i[AW+CW-1:AW];
        sram_addr_ <= wb.wb_adr_i[AW-1:0];
        sram_dq_o  <= wb.wb_dat_i;
        wait_cnt   <= 4'(WAIT);
      end else if (state == S_ACCESS && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == S_DONE) turn_cnt <= 2'((TURN > 0) ? TURN - 1 : 0);
      else if (state == S_TURN && turn_cnt != 2'd0) turn_cnt <= turn_cnt - 2'd1;
      // Out-of-range chips have no device behind them: reads float high.
      if (state == S_ACCESS && wait_cnt == 4'd0 && !req_we)
        wb.wb_dat_o <= (int'(req_chip) < NCHIPS) ? sram_dq_i : 16'hFFFF;
    end
  end

endmodule
